// File: rtl/seq_pattern_detector_if.sv
// Stream/control/status bundle for seq_pattern_detector.
// master drives the serial stream and pattern controls; slave is the detector.
interface seq_pattern_detector_if #(
   parameter int PAT_W = 4,
   parameter int CNT_W = 8
);
   logic             en;
   logic             d;
   logic             overlap;
   logic             pat_load;
   logic [PAT_W-1:0] pat_in;
   logic [PAT_W-1:0] mask_in;
   logic             cnt_clr;
   logic             z;
   logic [CNT_W-1:0] match_cnt;
   logic             cnt_sat;

   modport master (
      output en, d, overlap, pat_load, pat_in, mask_in, cnt_clr,
      input  z, match_cnt, cnt_sat
   );

   modport slave (
      input  en, d, overlap, pat_load, pat_in, mask_in, cnt_clr,
      output z, match_cnt, cnt_sat
   );
endinterface

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: masked compare of a shift history against a loadable
// pattern, overlapping/non-overlapping modes, registered pulse and saturating count.
module seq_pattern_detector #(
   parameter int               PAT_W    = 4,
   parameter int               CNT_W    = 8,
   parameter logic [PAT_W-1:0] PAT_INIT = 4'b1001
) (
   input logic                   clk,
   input logic                   reset,
   seq_pattern_detector_if.slave bus
);
   localparam int             FW        = $clog2(PAT_W + 1);
   localparam logic [FW-1:0]  FILL_FULL = FW'(PAT_W);

   logic [PAT_W-1:0] r_sh;
   logic [PAT_W-1:0] r_pat;
   logic [PAT_W-1:0] r_mask;
   logic [FW-1:0]    r_fill;
   logic             r_z;
   logic [CNT_W-1:0] r_cnt;
   logic             r_sat;

   logic [PAT_W-1:0] w_sh_next;
   logic [PAT_W-1:0] w_bit_ok;
   logic [FW-1:0]    w_fill_next;
   logic [CNT_W-1:0] w_cnt_inc;
   logic             w_shift;
   logic             w_match;
   logic             w_cnt_max;

   // A load takes priority over the stream bit on the same edge.
   assign w_shift     = bus.en & ~bus.pat_load;
   assign w_sh_next   = {r_sh[PAT_W-2:0], bus.d};
   assign w_fill_next = (r_fill == FILL_FULL) ? FILL_FULL : r_fill + FW'(1);

   for (genvar gi = 0; gi < PAT_W; gi++) begin : g_cmp
      assign w_bit_ok[gi] = ~r_mask[gi] | (w_sh_next[gi] ~^ r_pat[gi]);
   end

   assign w_match   = w_shift & (w_fill_next == FILL_FULL) & (&w_bit_ok);
   assign w_cnt_max = &r_cnt;
   assign w_cnt_inc = r_cnt + CNT_W'(1);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sh   <= '0;
         r_fill <= '0;
         r_pat  <= PAT_INIT;
         r_mask <= '1;
         r_z    <= 1'b0;
      end else if (bus.pat_load) begin
         r_pat  <= bus.pat_in;
         r_mask <= bus.mask_in;
         r_fill <= '0;
         r_z    <= 1'b0;
      end else if (bus.en) begin
         r_sh   <= w_sh_next;
         // Non-overlap mode restarts the fill so no bit is reused.
         r_fill <= (w_match && !bus.overlap) ? '0 : w_fill_next;
         r_z    <= w_match;
      end else begin
         r_z    <= 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (bus.cnt_clr) begin
         r_cnt <= '0;
         r_sat <= 1'b0;
      end else if (w_match && !w_cnt_max) begin
         r_cnt <= w_cnt_inc;
         r_sat <= r_sat | (&w_cnt_inc);
      end
   end

   assign bus.z         = r_z;
   assign bus.match_cnt = r_cnt;
   assign bus.cnt_sat   = r_sat;
endmodule
